serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Parametrised multi-cycle subtractor that computes `a - b - bin` over `WIDTH` bits, `DIGIT` bits per clock, LSB digit first. The borrow is registered between digits. It is the sequential, width-generic successor to the single-bit gate-level full-subtractor cell. It sits in datapaths where area matters more than latency, and is driven by a simple start/done handshake.

## Interface
- `WIDTH`, 16: operand and result width in bits.
- `DIGIT`, 4: bits processed per cycle. `WIDTH % DIGIT` must be 0, otherwise elaboration fails. N = `WIDTH/DIGIT`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request an operation; sampled only while idle.
- `a` input `WIDTH`: minuend, captured when `start` is accepted.
- `b` input `WIDTH`: subtrahend, captured when `start` is accepted.
- `bin` input 1: borrow-in, captured when `start` is accepted.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse when the result registers update.
- `diff` output `WIDTH`: result, `(a - b - bin) mod 2^WIDTH`.
- `borrow` output 1: final borrow out; 1 iff `a < b + bin` (unsigned).
- `ovf` output 1: signed overflow flag; see Configuration.

## Operation
- FSM has two states, IDLE and RUN; reset state is IDLE.
- IDLE, `start`=1 at an edge:
  - latch `a`, `b` and `bin`; the borrow register takes `bin`;
  - digit counter = 0;
  - go to RUN.
- RUN, one digit k per edge:
  - `d_k = a_k - b_k - borrow_reg`; the new borrow register value is the digit borrow out;
  - `d_k` is written into the working shift register;
  - counter increments.
- When digit N-1 is processed:
  - the working register is copied to `diff`;
  - the final borrow goes to `borrow`, and `ovf` updates;
  - `done` = 1 for one cycle;
  - go to IDLE.
- `diff`, `borrow` and `ovf` hold the previous result throughout RUN and change only when `done` rises.
- `start` while in RUN is ignored; the captured operands are unaffected.
- `start` high in the same cycle as `done` is accepted, giving back-to-back operation.
- Reset values: state IDLE, `busy`=0, `done`=0, `diff`=0, `borrow`=0, `ovf`=0, counter 0, working registers 0.
- `rst` during RUN aborts the operation: no `done` pulse, and all outputs return to their reset values at the next edge.
- `DIGIT == WIDTH` is legal: N = 1, fully parallel, one RUN cycle.

## Timing
- `start` sampled at edge E0.
- `busy` is high in the cycles after E0 through E(N-1) and falls after edge EN.
- `done` and the new `diff`/`borrow`/`ovf` appear after edge EN, i.e. N cycles after `start` is sampled. `done` is high for exactly one cycle.
- Throughput is one operation per N+1 cycles, with `start` re-asserted in the `done` cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `SERIAL_SUB_OVF_EN`.
- Defined:
  - `ovf` = (`a[MSB]` != `b[MSB]`) && (`diff[MSB]` != `a[MSB]`), using the captured operands;
  - `ovf` updates together with `diff` and holds until the next `done`.
- Undefined: the port still exists, is tied to 0, and the overflow logic is not built.

## Structure
- Shared package `serial_sub_pkg` contains:
  - the state typedef (IDLE, RUN);
  - a helper constant for the digit count N;
  - counter width = `$clog2(N)` with a minimum of 1.
- One sub-module, `digit_subtractor`: a combinational `DIGIT`-bit ripple slice of full-subtractor stages with borrow-in and borrow-out, instantiated once.

## Test plan
All scenarios use `WIDTH`=16, `DIGIT`=4, so N = 4.
- Reset: after `rst` is held for 2 cycles, `busy`, `done`, `diff`, `borrow` and `ovf` are all 0.
- `a`=0x1234, `b`=0x0234, `bin`=0 → `diff`=0x1000, `borrow`=0, `done` 4 cycles after `start`, `busy` high for 4 cycles.
- Wrap cases:
  - `a`=0x0000, `b`=0x0001, `bin`=0 → `diff`=0xFFFF, `borrow`=1;
  - `a`=0x0005, `b`=0x0005, `bin`=1 → `diff`=0xFFFF, `borrow`=1.
- Signed overflow: `a`=0x8000, `b`=0x0001 → `diff`=0x7FFF, `borrow`=0; `ovf`=1 with the macro, 0 without.
- Handshake:
  - `start` pulsed again in RUN with `a`=0xFFFF, `b`=0 → ignored, and the result still matches the first operation;
  - `start` asserted in the `done` cycle → second `done` exactly 5 cycles after the first.
- `rst` asserted in the 2nd RUN cycle → no `done`, all outputs 0; the next operation, 0x0010 - 0x0001, gives 0x000F with `borrow`=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the serial subtractor.
package serial_sub_pkg;

   // Controller states: waiting for start, or walking digits.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Number of digits processed per operation.
   function automatic int digit_count(input int width, input int digit);
      return width / digit;
   endfunction

   // Digit counter width, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-bit ripple of full-subtractor stages.
module digit_subtractor #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             bin,
   output logic [DIGIT-1:0] diff,
   output logic             bout
);

   logic br;

   // Ripple the borrow from the least significant stage upward.
   always_comb begin
      diff = '0;
      br   = bin;
      for (int unsigned i = 0; i < DIGIT; i++) begin
         diff[i] = a[i] ^ b[i] ^ br;
         br      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
      end
      bout = br;
   end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: a - b - bin over WIDTH bits, DIGIT bits per
// clock, LSB digit first, borrow registered between digits.
// Optional signed-overflow flag built when SERIAL_SUB_OVF_EN is defined;
// otherwise ovf is tied to 0.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf
);

   localparam int N  = digit_count(WIDTH, DIGIT);
   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
      $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
   end

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] work_next;
   logic             borrow_reg;
   logic [DIGIT-1:0] d_digit;
   logic             d_borrow;

`ifdef SERIAL_SUB_OVF_EN
   logic a_msb;
   logic b_msb;
`endif

   digit_subtractor #(
      .DIGIT (DIGIT)
   ) u_digit (
      .a    (a_sh[DIGIT-1:0]),
      .b    (b_sh[DIGIT-1:0]),
      .bin  (borrow_reg),
      .diff (d_digit),
      .bout (d_borrow)
   );

   // New digit enters at the top; after N shifts digit 0 sits at the bottom.
   // Written as shift/or so DIGIT == WIDTH needs no special-case slice.
   assign work_next = (work >> DIGIT) | (WIDTH'(d_digit) << (WIDTH - DIGIT));

   // Controller, operand shifters and registered result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         a_sh       <= '0;
         b_sh       <= '0;
         work       <= '0;
         borrow_reg <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
         ovf        <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh       <= a;
                  b_sh       <= b;
                  borrow_reg <= bin;
                  cnt        <= '0;
                  busy       <= 1'b1;
                  state      <= RUN;
`ifdef SERIAL_SUB_OVF_EN
                  a_msb      <= a[WIDTH-1];
                  b_msb      <= b[WIDTH-1];
`endif
               end
            end
            RUN: begin
               a_sh       <= a_sh >> DIGIT;
               b_sh       <= b_sh >> DIGIT;
               borrow_reg <= d_borrow;
               work       <= work_next;
               if (cnt == LAST) begin
                  cnt    <= '0;
                  diff   <= work_next;
                  borrow <= d_borrow;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
`ifdef SERIAL_SUB_OVF_EN
                  ovf    <= (a_msb != b_msb) && (work_next[WIDTH-1] != a_msb);
`endif
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef SERIAL_SUB_OVF_EN
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=16, DIGIT=4, N=4).
module tb_serial_subtractor;

   localparam int W = 16;
`ifdef SERIAL_SUB_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
   logic         ovf;

   int checks = 0;
   int fails  = 0;

   serial_subtractor #(
      .WIDTH (W),
      .DIGIT (4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .bin    (bin),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   // Reference: 17-bit unsigned subtraction; bit W is the borrow out.
   function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic bi);
      return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic bi);
      logic [W:0] r;
      r = ref_sub(x, y, bi);
      return OVF_EN && (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
   endfunction

   // Drive one operation; report latency, busy cycles and whether the
   // result outputs held their old values until done.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                         output int lat, output int busy_cycles, output bit held);
      logic [W-1:0] pd;
      logic         pb;
      logic         po;
      int           n;
      pd = diff;
      pb = borrow;
      po = ovf;
      @(negedge clk);
      a = x; b = y; bin = bi; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = -1; busy_cycles = 0; held = 1'b1;
      n = 1;
      while (n <= 40) begin
         if (done) begin
            lat = n - 1;
            break;
         end
         if (busy) busy_cycles++;
         if (diff !== pd || borrow !== pb || ovf !== po) held = 1'b0;
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (diff !== 16'h0000) begin fails++; $display("FAIL reset_diff: got %h want 0000", diff); end
      checks++; if (borrow !== 1'b0) begin fails++; $display("FAIL reset_borrow: got %b want 0", borrow); end
      checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat; int bc; bit held;
      run_op(16'h1234, 16'h0234, 1'b0, lat, bc, held);
      checks++; if (diff !== 16'h1000) begin fails++; $display("FAIL basic_diff: got %h want 1000", diff); end
      checks++; if (borrow !== 1'b0) begin fails++; $display("FAIL basic_borrow: got %b want 0", borrow); end
      checks++; if (lat !== 4) begin fails++; $display("FAIL basic_latency: got %0d want 4", lat); end
      checks++; if (bc !== 4) begin fails++; $display("FAIL basic_busy_cycles: got %0d want 4", bc); end
      checks++; if (held !== 1'b1) begin fails++; $display("FAIL basic_hold: outputs changed before done"); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: got %b want 0", done); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_wrap();
      int lat; int bc; bit held;
      run_op(16'h0000, 16'h0001, 1'b0, lat, bc, held);
      checks++; if (diff !== 16'hFFFF) begin fails++; $display("FAIL wrap1_diff: got %h want ffff", diff); end
      checks++; if (borrow !== 1'b1) begin fails++; $display("FAIL wrap1_borrow: got %b want 1", borrow); end
      run_op(16'h0005, 16'h0005, 1'b1, lat, bc, held);
      checks++; if (diff !== 16'hFFFF) begin fails++; $display("FAIL wrap2_diff: got %h want ffff", diff); end
      checks++; if (borrow !== 1'b1) begin fails++; $display("FAIL wrap2_borrow: got %b want 1", borrow); end
      checks++; if (lat !== 4) begin fails++; $display("FAIL wrap2_latency: got %0d want 4", lat); end
   endtask

   task automatic test_ovf();
      int lat; int bc; bit held;
      run_op(16'h8000, 16'h0001, 1'b0, lat, bc, held);
      checks++; if (diff !== 16'h7FFF) begin fails++; $display("FAIL ovf_diff: got %h want 7fff", diff); end
      checks++; if (borrow !== 1'b0) begin fails++; $display("FAIL ovf_borrow: got %b want 0", borrow); end
      checks++; if (ovf !== OVF_EN) begin fails++; $display("FAIL ovf_flag: got %b want %b", ovf, OVF_EN); end
   endtask

   task automatic test_ignore_start();
      int  n;
      bit  seen_done;
      bit  extra;
      @(negedge clk);
      a = 16'h5678; b = 16'h1234; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 16'hFFFF; b = 16'h0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen_done = 1'b0;
      n = 0;
      while (n < 20 && !seen_done) begin
         if (done) seen_done = 1'b1;
         else begin @(negedge clk); n++; end
      end
      checks++; if (seen_done !== 1'b1) begin fails++; $display("FAIL ignore_done: no done within 20 cycles"); end
      checks++; if (diff !== 16'h4444) begin fails++; $display("FAIL ignore_diff: got %h want 4444", diff); end
      checks++; if (borrow !== 1'b0) begin fails++; $display("FAIL ignore_borrow: got %b want 0", borrow); end
      extra = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done || busy) extra = 1'b1;
      end
      checks++; if (extra !== 1'b0) begin fails++; $display("FAIL ignore_no_second_op: got activity want none"); end
   endtask

   task automatic test_back_to_back();
      int lat; int bc; bit held;
      int k;
      run_op(16'h0100, 16'h0001, 1'b1, lat, bc, held);
      checks++; if (diff !== 16'h00FE) begin fails++; $display("FAIL b2b_first_diff: got %h want 00fe", diff); end
      a = 16'h00F0; b = 16'h0F00; bin = 1'b0; start = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         k++;
      end while (!done && k < 20);
      checks++; if (k !== 5) begin fails++; $display("FAIL b2b_spacing: got %0d want 5", k); end
      checks++; if (diff !== 16'hF1F0) begin fails++; $display("FAIL b2b_second_diff: got %h want f1f0", diff); end
      checks++; if (borrow !== 1'b1) begin fails++; $display("FAIL b2b_second_borrow: got %b want 1", borrow); end
   endtask

   task automatic test_reset_abort();
      int lat; int bc; bit held;
      bit extra;
      @(negedge clk);
      a = 16'h3333; b = 16'h1111; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin fails++; $display("FAIL abort_done: got %b want 0", done); end
      checks++; if (diff !== 16'h0000) begin fails++; $display("FAIL abort_diff: got %h want 0000", diff); end
      checks++; if (borrow !== 1'b0) begin fails++; $display("FAIL abort_borrow: got %b want 0", borrow); end
      checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL abort_ovf: got %b want 0", ovf); end
      extra = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done || busy) extra = 1'b1;
      end
      checks++; if (extra !== 1'b0) begin fails++; $display("FAIL abort_quiet: got activity want none"); end
      run_op(16'h0010, 16'h0001, 1'b0, lat, bc, held);
      checks++; if (diff !== 16'h000F) begin fails++; $display("FAIL abort_next_diff: got %h want 000f", diff); end
      checks++; if (borrow !== 1'b0) begin fails++; $display("FAIL abort_next_borrow: got %b want 0", borrow); end
      checks++; if (lat !== 4) begin fails++; $display("FAIL abort_next_latency: got %0d want 4", lat); end
   endtask

   task automatic test_random();
      int lat; int bc; bit held;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         bi;
      logic [W:0]   r;
      logic         o;
      for (int i = 0; i < 40; i++) begin
         x  = W'($urandom);
         y  = W'($urandom);
         bi = 1'($urandom_range(1, 0));
         if (i % 8 == 0) y = x;
         r  = ref_sub(x, y, bi);
         o  = ref_ovf(x, y, bi);
         run_op(x, y, bi, lat, bc, held);
         checks++; if (diff !== r[W-1:0]) begin fails++; $display("FAIL rand_diff[%0d]: %h-%h-%b got %h want %h", i, x, y, bi, diff, r[W-1:0]); end
         checks++; if (borrow !== r[W]) begin fails++; $display("FAIL rand_borrow[%0d]: %h-%h-%b got %b want %b", i, x, y, bi, borrow, r[W]); end
         checks++; if (ovf !== o) begin fails++; $display("FAIL rand_ovf[%0d]: %h-%h-%b got %b want %b", i, x, y, bi, ovf, o); end
         checks++; if (lat !== 4) begin fails++; $display("FAIL rand_latency[%0d]: got %0d want 4", i, lat); end
         checks++; if (held !== 1'b1) begin fails++; $display("FAIL rand_hold[%0d]: outputs changed before done", i); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_ovf();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
